// File: rtl/lbdr_input_fifo_if.sv
// ----------------------------------------------------------------------------
// lbdr_input_fifo_if
//   Handshake and data bundle between an input-port flit buffer and its
//   neighbours: the upstream router (valid_in/data_in, credit_out), the
//   downstream allocator (read_en) and LBDR (empty, data_out, decoded fields).
//
//   Modports
//     master : drives valid_in, data_in, read_en; observes everything else
//     slave  : the FIFO side
//
//   Signals
//     valid_in   upstream writes data_in this cycle
//     data_in    incoming flit
//     read_en    downstream pops the head flit
//     credit_out one-cycle pulse per popped flit
//     empty      no flit stored
//     full       every slot occupied
//     data_out   head flit, valid only when !empty
//     flit_id    data_out[31:29]
//     dst_addr   data_out[28:25]
//     err_ovf    sticky overflow flag
//     err_udf    sticky underflow flag
//     err_seq    sticky packet-sequence flag
// ----------------------------------------------------------------------------
interface lbdr_input_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic                  credit_out;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] data_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic                  err_ovf;
  logic                  err_udf;
  logic                  err_seq;

  modport master (
    output valid_in, data_in, read_en,
    input  credit_out, empty, full, data_out, flit_id, dst_addr,
           err_ovf, err_udf, err_seq
  );

  modport slave (
    input  valid_in, data_in, read_en,
    output credit_out, empty, full, data_out, flit_id, dst_addr,
           err_ovf, err_udf, err_seq
  );
endinterface

// File: rtl/lbdr_input_fifo.sv
// ----------------------------------------------------------------------------
// lbdr_input_fifo
//   Per-input-port flit buffer sitting directly in front of LBDR. Stores
//   incoming flits, presents the head flit first-word-fall-through, slices
//   flit_id / dst_addr out of the head for LBDR and returns one credit per
//   consumed flit to the upstream router.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : synchronous reset, active-low
//     bus  : lbdr_input_fifo_if.slave (see the interface file for signals)
//
//   Parameters
//     DATA_WIDTH : flit width; [31:29] flit_id, header [28:25] dst_addr
//     DEPTH      : number of slots, power of two, >= 2
//     PTR_W      : log2(DEPTH)
//
//   Build option
//     FIFO_ERR_CHECK_EN : when defined, sticky err_ovf / err_udf / err_seq
//                         detection is compiled in; otherwise those outputs
//                         are tied low. Drop/ignore behaviour is the same.
// ----------------------------------------------------------------------------
module lbdr_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                clk,
  input  logic                rst,
  lbdr_input_fifo_if.slave    bus
);

  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        count;
  logic                  credit_q;
  logic                  empty_i;
  logic                  full_i;
  logic                  rd;
  logic                  wr;

  // Flags come only from the count register, never from this cycle's inputs.
  assign empty_i = (count == '0);
  assign full_i  = (count == CNT_FULL);

  // No bypass: an empty FIFO never reads, so a same-cycle push just lands.
  // A full FIFO may push only because the head is leaving this same edge.
  assign rd = bus.read_en & ~empty_i;
  assign wr = bus.valid_in & (~full_i | rd);

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      credit_q <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr, rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      credit_q <= rd;
    end
  end

  assign bus.empty      = empty_i;
  assign bus.full       = full_i;
  assign bus.credit_out = credit_q;
  assign bus.data_out   = mem[rd_ptr];
  assign bus.flit_id    = bus.data_out[DATA_WIDTH-1 -: 3];
  assign bus.dst_addr   = bus.data_out[DATA_WIDTH-4 -: 4];

`ifdef FIFO_ERR_CHECK_EN
  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  logic [2:0] in_id;
  logic       in_pkt;
  logic       ovf_q;
  logic       udf_q;
  logic       seq_q;
  logic       seq_hit;

  assign in_id = bus.data_in[DATA_WIDTH-1 -: 3];

  // Only accepted writes advance the packet tracker; dropped flits are ignored.
  always_comb begin
    seq_hit = 1'b0;
    if (wr) begin
      if (in_id == FLIT_HEADER) begin
        seq_hit = in_pkt;
      end else if ((in_id == FLIT_BODY) || (in_id == FLIT_TAIL)) begin
        seq_hit = ~in_pkt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_pkt <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      if (wr && (in_id == FLIT_HEADER)) begin
        in_pkt <= 1'b1;
      end else if (wr && (in_id == FLIT_TAIL)) begin
        in_pkt <= 1'b0;
      end
      if (bus.valid_in && full_i && !rd) begin
        ovf_q <= 1'b1;
      end
      if (bus.read_en && empty_i) begin
        udf_q <= 1'b1;
      end
      if (seq_hit) begin
        seq_q <= 1'b1;
      end
    end
  end

  assign bus.err_ovf = ovf_q;
  assign bus.err_udf = udf_q;
  assign bus.err_seq = seq_q;
`else
  assign bus.err_ovf = 1'b0;
  assign bus.err_udf = 1'b0;
  assign bus.err_seq = 1'b0;
`endif

endmodule

// File: tb/tb_lbdr_input_fifo.sv
module tb_lbdr_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] BDY = 3'b010;
  localparam logic [2:0] TAL = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lbdr_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard of flits expected to appear at the head, oldest first.
  logic [DW-1:0] exp_q [$];

  int  errors = 0;
  int  checks = 0;
  int  m_cnt  = 0;
  bit  rd_prev, flush_pend, mon_en;
  bit  m_ovf, m_udf, m_seq, m_in_pkt;
  bit  exp_empty, exp_full, exp_credit, exp_ovf, exp_udf, exp_seq;

  function automatic logic [DW-1:0] flit(input logic [2:0] id, input logic [3:0] dst,
                                         input logic [3:0] src, input logic [20:0] pay);
    return {id, dst, src, pay};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus. exp_* describe the state the DUT holds before this
  // edge; the model is then advanced to what the edge should produce.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit rst_v);
    bit rd, wr;
    logic [2:0] id;
    if (flush_pend) begin
      exp_q.delete();
      flush_pend = 1'b0;
    end
    exp_empty  = (m_cnt == 0);
    exp_full   = (m_cnt == DEPTH);
    exp_credit = rd_prev;
`ifdef FIFO_ERR_CHECK_EN
    exp_ovf = m_ovf;
    exp_udf = m_udf;
    exp_seq = m_seq;
`else
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    exp_seq = 1'b0;
`endif
    rst          = rst_v;
    bus.valid_in = v;
    bus.data_in  = d;
    bus.read_en  = r;
    if (!rst_v) begin
      m_cnt      = 0;
      rd_prev    = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      m_seq      = 1'b0;
      m_in_pkt   = 1'b0;
      flush_pend = 1'b1;
    end else begin
      rd = r && (m_cnt > 0);
      wr = v && ((m_cnt < DEPTH) || rd);
      id = d[31:29];
      if (v && (m_cnt == DEPTH) && !rd) m_ovf = 1'b1;
      if (r && (m_cnt == 0))            m_udf = 1'b1;
      if (wr) begin
        exp_q.push_back(d);
        if (id == HDR) begin
          if (m_in_pkt) m_seq = 1'b1;
          m_in_pkt = 1'b1;
        end else if (id == BDY) begin
          if (!m_in_pkt) m_seq = 1'b1;
        end else if (id == TAL) begin
          if (!m_in_pkt) m_seq = 1'b1;
          m_in_pkt = 1'b0;
        end
      end
      if (wr && !rd)      m_cnt++;
      else if (rd && !wr) m_cnt--;
      rd_prev = rd;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares at the falling edge, pops the scoreboard on each pop
  // the DUT performs.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("empty",      {31'b0, bus.empty},      {31'b0, exp_empty});
      chk("full",       {31'b0, bus.full},       {31'b0, exp_full});
      chk("credit_out", {31'b0, bus.credit_out}, {31'b0, exp_credit});
      chk("err_ovf",    {31'b0, bus.err_ovf},    {31'b0, exp_ovf});
      chk("err_udf",    {31'b0, bus.err_udf},    {31'b0, exp_udf});
      chk("err_seq",    {31'b0, bus.err_seq},    {31'b0, exp_seq});
      if (!exp_empty) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
          chk("data_out", bus.data_out, exp_q[0]);
          chk("flit_id",  {29'b0, bus.flit_id},  {29'b0, exp_q[0][31:29]});
          chk("dst_addr", {28'b0, bus.dst_addr}, {28'b0, exp_q[0][28:25]});
        end
      end
      if (rst && bus.read_en && !bus.empty && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [DW-1:0] f [6];
    mon_en = 1'b0;
    step(0, '0, 0, 0);
    mon_en = 1'b1;

    // Header 0x2A00_0000: flit_id 001, dst_addr 5.
    step(1, 32'h2A00_0000, 0, 1);
    chk("hdr_flit_id",  {29'b0, bus.flit_id},  32'd1);
    chk("hdr_dst_addr", {28'b0, bus.dst_addr}, 32'd5);
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);

    // Fill to full, then a dropped 5th write.
    step(1, flit(BDY, 4'h0, 4'h1, 21'h00011), 0, 1);
    step(1, flit(BDY, 4'h0, 4'h1, 21'h00022), 0, 1);
    step(1, flit(BDY, 4'h0, 4'h1, 21'h00033), 0, 1);
    step(1, flit(TAL, 4'h0, 4'h1, 21'h00044), 0, 1);
    step(1, flit(HDR, 4'h9, 4'h2, 21'h0DEAD), 0, 1);
    step(0, '0, 0, 1);

    // Full with simultaneous push and pop for 6 cycles, across the wrap.
    f[0] = flit(HDR, 4'h3, 4'h2, 21'h10001);
    f[1] = flit(BDY, 4'h3, 4'h2, 21'h10002);
    f[2] = flit(TAL, 4'h3, 4'h2, 21'h10003);
    f[3] = flit(HDR, 4'hC, 4'h7, 21'h10004);
    f[4] = flit(BDY, 4'hC, 4'h7, 21'h10005);
    f[5] = flit(TAL, 4'hC, 4'h7, 21'h10006);
    for (int i = 0; i < 6; i++) step(1, f[i], 1, 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);

    // Empty FIFO: push and pop together stores without a credit.
    step(1, flit(HDR, 4'hA, 4'h4, 21'h0BEEF), 1, 1);
    step(0, '0, 0, 1);

    // Three flits held, reset asserted with read_en high.
    step(1, flit(BDY, 4'h0, 4'h4, 21'h00101), 0, 1);
    step(1, flit(BDY, 4'h0, 4'h4, 21'h00102), 0, 1);
    step(0, '0, 1, 0);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    // Packet-sequence and underflow cases.
    step(1, flit(HDR, 4'h1, 4'h0, 21'h00001), 0, 1);
    step(1, flit(HDR, 4'h2, 4'h0, 21'h00002), 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    step(1, flit(BDY, 4'h0, 4'h0, 21'h00003), 0, 1);
    step(0, '0, 1, 1);
    step(0, '0, 1, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
